// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and fixed-window access sequencer for one SRAM port.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer).
module sram_arbiter #(
    parameter int NREQ          = 3,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 128,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     sramRead,
    output logic                     sramWrite,
    output logic [ADDR_W-1:0]        sramAddr,
    output logic [DATA_W-1:0]        sramWriteValue,
    input  logic [DATA_W-1:0]        sramReadValue
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    logic                found_s;
    logic [IDX_W-1:0]    win_s;
    logic [IDX_W-1:0]    idx_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    // Winner search: first set req bit starting at the search origin
    always_comb begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
        logic [IDX_W:0] sum_v;
        sum_v = '0;
`endif
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            idx_s = IDX_W'(i);
`else
            sum_v = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum_v >= (IDX_W+1)'(NREQ)) begin
                sum_v = sum_v - (IDX_W+1)'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            idx_s = sum_v[IDX_W-1:0];
`endif
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Mux the winning requester's operation fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == IDX_W'(i)) begin
                sel_we_s    = req_we[i];
                sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
            end else begin
                sel_we_s    = sel_we_s;
            end
        end
    end

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    we_d    = sel_we_s;
                    addr_d  = sel_addr_s;
                    wdata_d = sel_wdata_s;
                    busy_d  = 1'b1;
                    rd_d    = ~sel_we_s;
                    wr_d    = sel_we_s;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    if (win_s == IDX_W'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_s + IDX_W'(1);
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = gnt_q;
                    if (!we_q) begin
                        rdata_d = sramReadValue;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign sramRead       = rd_q;
    assign sramWrite      = wr_q;
    assign sramAddr       = addr_q;
    assign sramWriteValue = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a small behavioural SRAM model.
module tb_sram_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;
    localparam int AC     = 2;

    localparam logic [127:0] W1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] W2 = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
    localparam logic [127:0] W3 = 128'hCAFEF00D_11112222_33334444_55556666;

    logic                   clk = 1'b0;
    logic                   n_rst = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        req_we = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   sramRead;
    logic                   sramWrite;
    logic [ADDR_W-1:0]      sramAddr;
    logic [DATA_W-1:0]      sramWriteValue;
    logic [DATA_W-1:0]      sramReadValue;

    logic [DATA_W-1:0]      mem [256];
    int                     n_checks = 0;
    int                     n_errors = 0;

    sram_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .sramRead(sramRead), .sramWrite(sramWrite),
        .sramAddr(sramAddr), .sramWriteValue(sramWriteValue),
        .sramReadValue(sramReadValue)
    );

    always #5 clk = ~clk;

    assign sramReadValue = mem[sramAddr[7:0]];
    always @(posedge clk) begin
        if (sramWrite) mem[sramAddr[7:0]] <= sramWriteValue;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = 7;
        for (int i = 0; i < NREQ; i++) if (v == (3'b001 << i)) r = i;
        return r;
    endfunction

    // One isolated access by requester r, checked cycle by cycle
    task automatic run_access(input int r, input logic we, input logic [15:0] a,
                              input logic [127:0] wd, input logic [127:0] exp_rd);
        logic [2:0] oh;
        logic [1:0] strb;
        oh   = 3'b001 << r;
        strb = we ? 2'b01 : 2'b10;
        req_we[r] = we;
        req_addr[r*ADDR_W +: ADDR_W] = a;
        req_wdata[r*DATA_W +: DATA_W] = wd;
        req[r] = 1'b1;
        tick();
        check_val("acc_gnt", gnt, oh);
        check_val("acc_busy", busy, 1);
        check_val("acc_addr", sramAddr, a);
        check_val("acc_strobe1", {sramRead, sramWrite}, strb);
        tick();
        check_val("acc_strobe2", {sramRead, sramWrite}, strb);
        check_val("acc_nodone", done, 0);
        tick();
        check_val("acc_done", done, oh);
        check_val("acc_strobe_off", {sramRead, sramWrite}, 2'b00);
        check_val("acc_rdata", rdata, exp_rd);
        req[r] = 1'b0;
        tick();
        check_val("acc_idle_busy", busy, 0);
        check_val("acc_idle_gnt", gnt, 0);
    endtask

    initial begin
        int order [6];
        int dcyc [6];
        int nd;
        int exp_order [6];
        int d1, d2, g1_rise;
        logic g1_prev;
        logic [127:0] rd_at;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = W1;
        mem[8'h04] = W3;
        mem[8'h08] = ~W3;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_gnt", gnt, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_strobes", {sramRead, sramWrite}, 2'b00);
        check_val("rst_addr", sramAddr, 0);
        check_val("rst_wval", sramWriteValue, 0);
        @(negedge clk) n_rst = 1'b1;

        // All three requesters held: grant order and done spacing
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        req_we = 3'b000;
        req_addr = {16'h0022, 16'h0021, 16'h0020};
        req = 3'b111;
        nd = 0;
        for (int c = 0; c < 60 && nd < 6; c++) begin
            tick();
            if (done != 0) begin
                order[nd] = onehot_idx(done);
                dcyc[nd] = c;
                nd++;
                if (nd == 6) req = 3'b000;
            end
        end
        check_val("rr_count", nd, 6);
        for (int k = 0; k < nd; k++) check_val($sformatf("rr_order%0d", k), order[k], exp_order[k]);
        for (int k = 1; k < nd; k++) check_val($sformatf("rr_space%0d", k), dcyc[k] - dcyc[k-1], AC + 2);
        tick();

        // Single reads and writes
        run_access(1, 1'b0, 16'h0010, '0, W1);
        run_access(0, 1'b1, 16'h00FF, W2, W1);
        run_access(2, 1'b0, 16'h00FF, '0, W2);

        // Address change after grant is ignored
        req_we[0] = 1'b0;
        req_addr[0 +: ADDR_W] = 16'h0004;
        req[0] = 1'b1;
        tick();
        check_val("lat_addr1", sramAddr, 16'h0004);
        req_addr[0 +: ADDR_W] = 16'h0008;
        tick();
        check_val("lat_addr2", sramAddr, 16'h0004);
        tick();
        check_val("lat_rdata", rdata, W3);
        req[0] = 1'b0;
        tick();

        // Reset in the second access cycle of a write, then drop a req mid-access
        req_we[1] = 1'b1;
        req_addr[1*ADDR_W +: ADDR_W] = 16'h0030;
        req_wdata[1*DATA_W +: DATA_W] = W3;
        req[1] = 1'b1;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check_val("mrst_write", sramWrite, 0);
        check_val("mrst_gnt", gnt, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_done", done, 0);
        check_val("mrst_rdata", rdata, 0);
        req_we[2] = 1'b0;
        req_addr[2*ADDR_W +: ADDR_W] = 16'h00FF;
        req = 3'b110;
        @(negedge clk) n_rst = 1'b1;
        tick();
        check_val("mrst_first_gnt", gnt, 3'b010);
        req[1] = 1'b0;
        d1 = 0;
        d2 = 0;
        g1_rise = 0;
        g1_prev = 1'b1;
        rd_at = '0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (done[1]) d1++;
            if (done[2]) begin
                d2++;
                rd_at = rdata;
                req[2] = 1'b0;
            end
            if (gnt[1] && !g1_prev) g1_rise++;
            g1_prev = gnt[1];
        end
        check_val("drop_done1", d1, 1);
        check_val("drop_done2", d2, 1);
        check_val("drop_regrant1", g1_rise, 0);
        check_val("drop_rdata2", rd_at, W2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter and access sequencer for the single 128-bit test SRAM port (read/write strobes, 16-bit address, 128-bit write/read data). Up to NREQ datapath blocks, for example the around-wrap engine and the dump/init loaders, request word accesses. The arbiter grants one requester at a time, holds the SRAM strobes for a fixed access window, captures read data and returns a one-cycle done pulse. It sits between the requesting engines and the SRAM model/macro.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 16, SRAM address width
- DATA_W, 128, SRAM data width
- ACCESS_CYCLES, 2, cycles the strobes are held per access (1..15)

Ports:
- clk  in  1  single clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held high until its done pulse
- req_we  in  NREQ  per-requester write enable (1 = write, 0 = read)
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data, same packing
- gnt  out  NREQ  one-hot grant, high from access start through the done cycle
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  registered read data, valid in the done cycle
- busy  out  1  high whenever the FSM is not IDLE
- sramRead  out  1  SRAM read strobe
- sramWrite  out  1  SRAM write strobe
- sramAddr  out  ADDR_W  SRAM address
- sramWriteValue  out  DATA_W  SRAM write data
- sramReadValue  in  DATA_W  SRAM read data (combinational from the SRAM)

## Operation
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If any req bit is high, select the winner, latch its we/addr/wdata into internal registers, set gnt, load the access counter with ACCESS_CYCLES-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - sramAddr and sramWriteValue are driven from the latched registers.
  - sramRead equals the latched ~we; sramWrite equals the latched we. Exactly one strobe is high.
  - The counter decrements every cycle.
  - When the counter reaches 0, go to DONE on that edge. For a read, capture sramReadValue into rdata on the same edge.
- DONE:
  - done[winner] is high for exactly one cycle.
  - Both strobes are low.
  - Next state is IDLE, and gnt clears on that edge.
- Winner selection is round-robin:
  - The search starts at ptr and goes upward, wrapping modulo NREQ. The first set req bit wins.
  - ptr is updated to (winner+1) mod NREQ on the grant edge.
  - ptr resets to 0.
- The latched requester inputs are ignored after the grant edge. Changes to req_addr, req_wdata or req_we during ACCESS have no effect.
- rdata holds its last captured value until the next read completes. Writes do not change rdata.
- A req that is still high in the cycle after its done pulse is treated as a new request.
- A req that drops before done does not abort the access. The access completes and done still pulses.

## Timing
- Reset values: gnt=0, done=0, rdata=0, busy=0, sramRead=0, sramWrite=0, sramAddr=0, sramWriteValue=0, FSM in IDLE, ptr=0, counter=0.
- Reset mid-access clears everything above asynchronously. The strobes drop immediately and no done is issued.
- Latency: a req sampled high in IDLE at edge T gives:
  - strobes high for cycles T..T+ACCESS_CYCLES-1;
  - done high in the cycle after edge T+ACCESS_CYCLES;
  - IDLE again after edge T+ACCESS_CYCLES+1.
- Throughput is one access per ACCESS_CYCLES+2 cycles. There is no back-to-back grant without passing through IDLE.
- Simultaneous requests are resolved in the same IDLE cycle by round-robin. The losers keep req high and are served in subsequent rounds.
- Worst-case wait for any held request is (NREQ-1)*(ACCESS_CYCLES+2) cycles after it is first sampled in IDLE.
- Pointer wrap: with NREQ=3 and ptr=2, the search order is 2, 0, 1.

## Configuration
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is not implemented, and requester 0 can starve the others.
- Undefined (default): round-robin exactly as described above.

## Test plan
- Reset, then requester 1 reads addr 0x0010 holding 0xDEADBEEF_... (128-bit) with ACCESS_CYCLES=2 -> sramRead high for 2 cycles with sramAddr=0x0010; done[1] pulses on the 3rd cycle with rdata equal to the stored word; then IDLE.
- Requester 0 writes 0x0123..CDEF to addr 0x00FF, then requester 2 reads 0x00FF -> sramWrite high for 2 cycles; the read returns 0x0123..CDEF; rdata is unchanged by the write.
- All three req held high from reset -> grant order 0, 1, 2, 0, 1, 2; each done is separated by 4 cycles. With SRAM_ARB_FIXED_PRIO_EN defined, the order is 0, 0, 0.
- req_addr changed from 0x0004 to 0x0008 in the first ACCESS cycle -> sramAddr stays 0x0004 for the whole access.
- n_rst asserted in the 2nd ACCESS cycle of a write -> sramWrite, gnt and busy go to 0 immediately; no done pulse; the first grant after release goes to the lowest pending requester (ptr=0).
- req[1] dropped mid-access -> done[1] still pulses once; no further grant to requester 1.
